// File: rtl/ysyx_24090003_ctrl_fsm_if.sv
// ysyx_24090003_ctrl_fsm_if: fetch and memory request/response handshakes between the sequencer and IFU/LSU
interface ysyx_24090003_ctrl_fsm_if;
  logic ifu_req_valid;
  logic ifu_req_ready;
  logic ifu_rsp_valid;
  logic [31:0] inst_in;
  logic lsu_req_valid;
  logic lsu_req_wen;
  logic lsu_req_ready;
  logic lsu_rsp_valid;
  modport master(
    output ifu_req_valid, lsu_req_valid, lsu_req_wen,
    input ifu_req_ready, ifu_rsp_valid, inst_in, lsu_req_ready, lsu_rsp_valid
  );
  modport slave(
    input ifu_req_valid, lsu_req_valid, lsu_req_wen,
    output ifu_req_ready, ifu_rsp_valid, inst_in, lsu_req_ready, lsu_rsp_valid
  );
endinterface

// File: rtl/ysyx_24090003_ctrl_fsm.sv
// ysyx_24090003_ctrl_fsm: multi-cycle fetch/decode/execute/memory/writeback sequencer for the NPC core
module ysyx_24090003_ctrl_fsm #(
  parameter int TIMEOUT = 256,
  parameter int RET_W = 32
) (
  input logic clk,
  input logic rst,
  ysyx_24090003_ctrl_fsm_if.master bus,
  output logic [31:0] inst_out,
  output logic rf_we,
  output logic pc_we,
  output logic [RET_W-1:0] retired,
  output logic halt,
  output logic err
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [3:0] {
    RESET, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR
  } stateT;
  stateT state, nextState;
  logic [TW-1:0] timer;
  logic isLoad, isStore, isBranch, isEbreak, timeUp;
  always_comb begin
    isLoad = inst_out[6:0] == 7'b0000011;
    isStore = inst_out[6:0] == 7'b0100011;
    isBranch = inst_out[6:0] == 7'b1100011;
    isEbreak = inst_out == 32'h00100073;
    timeUp = timer == TW'(TIMEOUT - 1);
  end
  // a response in the last allowed wait cycle still wins over the timeout
  always_comb begin
    nextState = state;
    case (state)
      RESET: nextState = FETCH_REQ;
      FETCH_REQ: nextState = bus.ifu_req_ready ? FETCH_WAIT : FETCH_REQ;
      FETCH_WAIT: nextState = bus.ifu_rsp_valid ? DECODE : timeUp ? ERR : FETCH_WAIT;
      DECODE: nextState = isEbreak ? HALT : EXEC;
      EXEC: nextState = (isLoad || isStore) ? MEM_REQ : WB;
      MEM_REQ: nextState = bus.lsu_req_ready ? MEM_WAIT : MEM_REQ;
      MEM_WAIT: nextState = bus.lsu_rsp_valid ? WB : timeUp ? ERR : MEM_WAIT;
      WB: nextState = FETCH_REQ;
      default: nextState = state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET;
      inst_out <= 32'h00000013;
      retired <= '0;
      timer <= '0;
    end else begin
      state <= nextState;
      if (state == FETCH_WAIT && bus.ifu_rsp_valid) inst_out <= bus.inst_in;
      if (state == WB) retired <= retired + 1'b1;
      timer <= (state == FETCH_WAIT || state == MEM_WAIT) ? timer + 1'b1 : '0;
    end
  end
  always_comb begin
    bus.ifu_req_valid = state == FETCH_REQ;
    bus.lsu_req_valid = state == MEM_REQ;
    bus.lsu_req_wen = state == MEM_REQ && isStore;
    pc_we = state == WB;
    rf_we = state == WB && !isStore && !isBranch;
    halt = state == HALT || state == ERR;
    err = state == ERR;
  end
endmodule

// File: tb/tb_ysyx_24090003_ctrl_fsm.sv
// tb_ysyx_24090003_ctrl_fsm: directed latency pins plus randomized handshakes checked against a
// procedural, instruction-at-a-time model of the sequencer
module tb_ysyx_24090003_ctrl_fsm;
  localparam int TO = 4;
  localparam int RW = 4;
  localparam logic [31:0] NOP = 32'h00000013, ADDI = 32'h00500093, LD = 32'h0000A103;
  localparam logic [31:0] ST = 32'h00112023, BR = 32'h00000463, EBRK = 32'h00100073;
  logic clk = 0, rst = 1;
  logic [31:0] instOut;
  logic rfWe, pcWe, halt, err;
  logic [RW-1:0] retired;
  ysyx_24090003_ctrl_fsm_if bus();
  ysyx_24090003_ctrl_fsm #(.TIMEOUT(TO), .RET_W(RW)) dut (
    .clk(clk), .rst(rst), .bus(bus), .inst_out(instOut), .rf_we(rfWe),
    .pc_we(pcWe), .retired(retired), .halt(halt), .err(err)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0;
  // model: walks one instruction at a time, reacting to inputs seen at each rising edge
  bit chk = 0, mRst, sIr, sIv, sLr, sLv;
  logic [31:0] sInst;
  logic eIfu, eLsu, eWen, eRf, ePc, eHalt, eErr;
  logic [31:0] eInst;
  logic [RW-1:0] eRet;
  task automatic tick();
    @(posedge clk);
    mRst = rst;
    sIr = bus.ifu_req_ready;
    sIv = bus.ifu_rsp_valid;
    sLr = bus.lsu_req_ready;
    sLv = bus.lsu_rsp_valid;
    sInst = bus.inst_in;
  endtask
  task automatic quiet();
    {eIfu, eLsu, eWen, eRf, ePc} = '0;
  endtask
  task automatic park();
    do tick(); while (!mRst);
  endtask
  // res: 0 response, 1 timed out, 2 reset
  task automatic waitRsp(input bit ifu, output int res);
    int n = 0;
    forever begin
      tick();
      n++;
      if (mRst) begin res = 2; return; end
      if (ifu ? sIv : sLv) begin res = 0; return; end
      if (n == TO) begin res = 1; return; end
    end
  endtask
  task automatic run();
    int res;
    logic [31:0] ins;
    bit isSt, isBr, isLd;
    forever begin
      quiet();
      eIfu = 1;
      do begin tick(); if (mRst) return; end while (!sIr);
      eIfu = 0;
      waitRsp(1, res);
      if (res == 2) return;
      if (res == 1) begin eHalt = 1; eErr = 1; park(); return; end
      ins = sInst;
      eInst = ins;
      isLd = ins[6:0] == 7'b0000011;
      isSt = ins[6:0] == 7'b0100011;
      isBr = ins[6:0] == 7'b1100011;
      tick();
      if (mRst) return;
      if (ins == EBRK) begin eHalt = 1; park(); return; end
      tick();
      if (mRst) return;
      if (isLd || isSt) begin
        eLsu = 1;
        eWen = isSt;
        do begin tick(); if (mRst) return; end while (!sLr);
        eLsu = 0;
        eWen = 0;
        waitRsp(0, res);
        if (res == 2) return;
        if (res == 1) begin eHalt = 1; eErr = 1; park(); return; end
      end
      ePc = 1;
      eRf = !(isSt || isBr);
      tick();
      if (mRst) return;
      eRet = eRet + 1'b1;
    end
  endtask
  initial begin
    do tick(); while (!mRst);
    forever begin
      quiet();
      eHalt = 0;
      eErr = 0;
      eInst = NOP;
      eRet = '0;
      chk = 1;
      tick();
      if (!mRst) run();
    end
  end
  task automatic cmp();
    logic [6:0] act, exp;
    act = {bus.ifu_req_valid, bus.lsu_req_valid, bus.lsu_req_wen & eLsu, rfWe, pcWe, halt, err};
    exp = {eIfu, eLsu, eWen, eRf, ePc, eHalt, eErr};
    vectors++;
    if (act !== exp || instOut !== eInst || retired !== eRet) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL cycle t=%0t ifu/lsu/wen/rf/pc/halt/err got %b want %b inst got %h want %h retired got %0d want %0d",
                 $time, act, exp, instOut, eInst, retired, eRet);
    end
  endtask
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    if (chk) cmp();
    @(posedge clk);
    #1;
  endtask
  logic [63:0] hIfu, hLsu, hWen, hRf, hPc, hHalt, hErr;
  logic [31:0] hInst [64];
  logic [RW-1:0] hRet [64];
  // cycle 0 is the first cycle after reset is released; masks give each input per cycle
  task automatic runDir(input logic [31:0] ins, input logic [63:0] ir, iv, lr, lv, rm, input int n);
    rst = 1;
    step();
    bus.inst_in = ins;
    for (int c = 0; c < n; c++) begin
      rst = rm[c];
      bus.ifu_req_ready = ir[c];
      bus.ifu_rsp_valid = iv[c];
      bus.lsu_req_ready = lr[c];
      bus.lsu_rsp_valid = lv[c];
      @(negedge clk);
      hIfu[c] = bus.ifu_req_valid;
      hLsu[c] = bus.lsu_req_valid;
      hWen[c] = bus.lsu_req_wen;
      hRf[c] = rfWe;
      hPc[c] = pcWe;
      hHalt[c] = halt;
      hErr[c] = err;
      hInst[c] = instOut;
      hRet[c] = retired;
      if (chk) cmp();
      @(posedge clk);
      #1;
    end
  endtask
  function automatic logic [31:0] pick();
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 15);
    return k < 4 ? {w[31:7], 7'h13} : k < 7 ? {w[31:7], 7'h03} : k < 10 ? {w[31:7], 7'h23} :
           k < 12 ? {w[31:7], 7'h63} : k == 12 ? EBRK : w;
  endfunction
  initial begin
    bus.ifu_req_ready = 0;
    bus.ifu_rsp_valid = 0;
    bus.lsu_req_ready = 0;
    bus.lsu_rsp_valid = 0;
    bus.inst_in = NOP;
    @(posedge clk);
    #1;
    step();
    runDir(ADDI, '1, '1, '1, '1, '0, 12);
    lit("rst_inst", hInst[0], NOP);
    lit("rst_ret", 32'(hRet[0]), 0);
    lit("alu_ifu_c0", hIfu[0], 0);
    lit("alu_ifu_c1", hIfu[1], 1);
    lit("alu_inst_c3", hInst[3], ADDI);
    lit("alu_pc_c4", hPc[4], 0);
    lit("alu_pc_c5", hPc[5], 1);
    lit("alu_rf_c5", hRf[5], 1);
    lit("alu_ret_c6", 32'(hRet[6]), 1);
    lit("alu_pc_c10", hPc[10], 1);
    lit("alu_ret_c11", 32'(hRet[11]), 2);
    runDir(LD, '1, '1, '1, '1, '0, 10);
    lit("ld_lsu_c5", hLsu[5], 1);
    lit("ld_wen_c5", hWen[5], 0);
    lit("ld_pc_c6", hPc[6], 0);
    lit("ld_pc_c7", hPc[7], 1);
    lit("ld_rf_c7", hRf[7], 1);
    runDir(ST, '1, '1, '1, '1, '0, 10);
    lit("st_wen_c5", hWen[5], 1);
    lit("st_pc_c7", hPc[7], 1);
    lit("st_rf_c7", hRf[7], 0);
    runDir(BR, '1, '1, '1, '1, '0, 12);
    lit("br_pc_c5", hPc[5], 1);
    lit("br_rf_c5", hRf[5], 0);
    lit("br_lsu", 32'(hLsu[11:0]), 0);
    runDir(ADDI, ~64'h7FE, '1, '1, '1, '0, 18);
    lit("stall_ifu", 32'(hIfu[12:1]), 32'h7FF);
    lit("stall_pc_c15", hPc[15], 1);
    lit("stall_ret_c16", 32'(hRet[16]), 1);
    runDir(ADDI, '1, '0, '1, '1, '0, 10);
    lit("to_err_c5", hErr[5], 0);
    lit("to_err_c6", hErr[6], 1);
    lit("to_halt_c6", hHalt[6], 1);
    lit("to_sticky", 32'({hErr[9], hIfu[9:7]}), 32'h8);
    runDir(ADDI, '1, 64'h20, '1, '1, '0, 10);
    lit("late_err_c6", hErr[6], 0);
    lit("late_inst_c6", hInst[6], ADDI);
    lit("late_pc_c8", hPc[8], 1);
    runDir(EBRK, '1, '1, '1, '1, '0, 12);
    lit("eb_halt_c3", hHalt[3], 0);
    lit("eb_halt_c4", hHalt[4], 1);
    lit("eb_err_c4", hErr[4], 0);
    lit("eb_noreq", 32'(hIfu[11:4]), 0);
    lit("eb_ret", 32'(hRet[11]), 0);
    runDir(LD, '1, '1, '1, '0, 64'h80, 10);
    lit("mrst_inst_c7", hInst[7], LD);
    lit("mrst_inst_c8", hInst[8], NOP);
    lit("mrst_ifu_c8", hIfu[8], 0);
    lit("mrst_ifu_c9", hIfu[9], 1);
    rst = 1;
    step();
    for (int c = 0; c < 4000; c++) begin
      int pr = (c / 500) % 2 == 0 ? 75 : 35;
      rst = $urandom_range(0, 299) == 0 || (eHalt && $urandom_range(0, 3) == 0);
      bus.ifu_req_ready = $urandom_range(0, 2) != 0;
      bus.ifu_rsp_valid = $urandom_range(0, 99) < pr;
      bus.lsu_req_ready = $urandom_range(0, 2) != 0;
      bus.lsu_rsp_valid = $urandom_range(0, 99) < pr;
      bus.inst_in = pick();
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ysyx_24090003_ctrl_fsm.md
Name: ysyx_24090003_ctrl_fsm

Overview:
Multi-cycle sequencer for the single-issue NPC core. It fetches one instruction at a time over valid/ready handshakes, latches it into the instruction register that feeds the decoder and immediate generator, and steps the datapath through decode, execute, memory and writeback. It emits one-cycle register-file and PC write strobes, a retire counter, and sticky halt/error status for the simulation harness.

Parameters:
TIMEOUT, 256, max cycles spent waiting for an IFU or LSU response before entering ERR (must be >= 2)
RET_W, 32, width of retired-instruction counter

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
ifu_req_valid  output  1  fetch request
ifu_req_ready  input  1  IFU accepts request
ifu_rsp_valid  input  1  fetched instruction valid on inst_in
inst_in  input  32  fetched instruction
inst_out  output  32  latched instruction register, to decoder/ImmT
lsu_req_valid  output  1  memory request
lsu_req_wen  output  1  1 = store, 0 = load; valid with lsu_req_valid
lsu_req_ready  input  1  LSU accepts request
lsu_rsp_valid  input  1  LSU done (load data valid / store committed)
rf_we  output  1  register-file write strobe
pc_we  output  1  PC update strobe
retired  output  RET_W  retired-instruction count
halt  output  1  sticky; core stopped
err  output  1  sticky; response timeout

Behaviour:
- Single clock, clk. Reset is synchronous and active-high on rst. rst wins over every other input in every state, including mid-handshake.
- Reset values: state RESET, inst_out = 0x00000013 (nop), retired = 0, timer = 0. All strobes and valids are 0. halt = err = 0.
- Decode uses inst_out[6:0]. Load = 0000011. Store = 0100011. Branch = 1100011. ebreak = full word 0x00100073.
- States and transitions:
  - RESET: 1 cycle, then FETCH_REQ.
  - FETCH_REQ: ifu_req_valid = 1. On ifu_req_ready, go to FETCH_WAIT and clear timer. Otherwise hold; valid stays high and the request cannot be withdrawn.
  - FETCH_WAIT: ifu_rsp_valid is sampled only here, so the earliest response is the cycle after acceptance. On rsp, inst_out <= inst_in and go to DECODE. Otherwise timer++. When timer == TIMEOUT-1 with no rsp, go to ERR. If rsp and the timeout coincide, rsp wins.
  - DECODE: 1 cycle. If inst_out is ebreak, go to HALT. Otherwise go to EXEC.
  - EXEC: 1 cycle. Load or store goes to MEM_REQ; anything else goes to WB.
  - MEM_REQ: lsu_req_valid = 1 and lsu_req_wen = store. On lsu_req_ready, go to MEM_WAIT and clear timer.
  - MEM_WAIT: same response and timeout rules as FETCH_WAIT, using lsu_rsp_valid. On rsp, go to WB.
  - WB: 1 cycle. pc_we = 1. rf_we = 1 unless the instruction is a store or branch. retired++ (wraps modulo 2^RET_W). Then go to FETCH_REQ.
  - HALT: halt = 1. Terminal until rst. No request is issued and retired does not count the ebreak.
  - ERR: err = 1 and halt = 1. Terminal until rst.
- inst_out is stable from its DECODE entry until the next FETCH_WAIT response.
- Responses arriving outside the WAIT states are ignored.
- All outputs are registered or derived purely from state; there is no combinational path from inputs to outputs.
- Minimum latency with ready and rsp asserted at the earliest cycle:
  - ALU op: 5 cycles from FETCH_REQ to the WB strobe.
  - Load/store: 7 cycles.

Test Plan:
- Always-ready IFU returning 0x00500093 (addi) -> ifu_req_valid in cycle 1 after reset release; pc_we and rf_we pulse once in cycle 5; retired = 1; back-to-back repeats retire every 5 cycles.
- Load 0x0000A103, LSU ready immediately with rsp 1 cycle later -> lsu_req_valid = 1 with lsu_req_wen = 0; rf_we and pc_we in cycle 7.
- Store 0x00112023 -> lsu_req_wen = 1; WB asserts pc_we = 1 and rf_we = 0; branch 0x00000463 -> no LSU request, rf_we = 0, pc_we = 1.
- ifu_req_ready held low 10 cycles -> ifu_req_valid stays 1 throughout, no state advance; ready then rsp -> normal retire.
- TIMEOUT = 4, no ifu_rsp_valid -> err = 1 and halt = 1 exactly 4 cycles after acceptance; rsp arriving on the final cycle instead -> DECODE, no err.
- Fetch 0x00100073 -> halt = 1 two cycles after rsp, retired unchanged, no further requests; rst asserted mid-MEM_WAIT -> all outputs return to reset values the next cycle.
